// File: rtl/serial_bus_pkg.sv
// Shared definitions for the 1-bit serial bus between the arbiter and its slaves.
// Holds the state encoding and the default geometry.
package serial_bus_pkg;

    localparam int ADN_DEF  = 12;
    localparam int N_DEF    = 8;
    localparam int MEMN_DEF = 2;
    localparam int SSEL_W   = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/serial_reg_slave_if.sv
// Arbiter <-> slave serial bus bundle.
// The master drives the request side; the slave drives ready and read data.
interface serial_reg_slave_if;

    logic valid_in;
    logic wr_en;
    logic burst;
    logic addr;
    logic data_in;
    logic ready;
    logic valid_out;
    logic data_out;

    modport master (
        output valid_in, wr_en, burst, addr, data_in,
        input  ready, valid_out, data_out
    );

    modport slave (
        input  valid_in, wr_en, burst, addr, data_in,
        output ready, valid_out, data_out
    );

endinterface

// File: rtl/serial_shift_unit.sv
// LSB-first shift register with a bit counter.
// Shifting right both collects serial input at the top and exposes output at q[0].
module serial_shift_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt,
    output logic         first,
    output logic         last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [W-1:0]  r_q;
    logic [CW-1:0] r_cnt;

    assign q     = r_q;
    assign q_nxt = {sin, r_q[W-1:1]};
    assign first = (r_cnt == '0);
    assign last  = (r_cnt == C_LAST);

    // The counter wraps after W shifts so back-to-back words need no clear.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_q   <= load_val;
            r_cnt <= '0;
        end else if (shift) begin
            r_q   <= q_nxt;
            r_cnt <= last ? '0 : r_cnt + C_ONE;
        end
    end

endmodule

// File: rtl/serial_reg_slave.sv
// Serial-bus register slave: 2^MemN x N bank written and read over the 1-bit bus,
// with a write-notify strobe and a registered peripheral read port.
module serial_reg_slave
    import serial_bus_pkg::*;
#(
    parameter int MemN     = MEMN_DEF,
    parameter int N        = N_DEF,
    parameter int ADN      = ADN_DEF,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    serial_reg_slave_if.slave   bus,
    output logic                wr_strobe,
    output logic [MemN-1:0]     wr_addr,
    output logic [N-1:0]        wr_data,
    input  logic [MemN-1:0]     p_addr,
    output logic [N-1:0]        p_rdata,
    output logic                abort,
    output logic [2:0]          state_out
);

    localparam logic [2:0]      LAT_M1  = 3'(READ_LAT - 1);
    localparam logic [MemN-1:0] IDX_ONE = MemN'(1);

    state_t          r_state;
    logic            r_ready, r_valid, r_dout;
    logic            r_wr_strobe, r_abort;
    logic            r_wr_en, r_burst, r_cont;
    logic [MemN-1:0] r_idx, r_wr_addr;
    logic [N-1:0]    r_wr_data, r_prdata;
    logic [2:0]      r_wcnt;
    logic [N-1:0]    r_mem [2**MemN];

    logic [ADN-1:0]  w_aq, w_anxt;
    logic            w_afirst, w_alast, w_ashift, w_aclr;
    logic [N-1:0]    w_dq, w_dnxt, w_load_word;
    logic            w_dfirst, w_dlast, w_dshift, w_dclr, w_dload;
    logic [MemN-1:0] w_load_idx;
    logic            w_commit, w_in_addr, w_unused;

    assign w_in_addr = (r_state == IDLE) || (r_state == ADDR);
    assign w_ashift  = bus.valid_in && w_in_addr;
    assign w_aclr    = !w_in_addr || ((r_state == ADDR) && !bus.valid_in);

    assign w_commit = (r_state == WDATA) && bus.valid_in && w_dlast;
    assign w_dshift = ((r_state == WDATA) && bus.valid_in)
                   || ((r_state == RDATA) && !w_dlast);
    assign w_dclr   = (r_state == DONE) || ((r_state == WDATA) && !bus.valid_in);
    assign w_dload  = ((r_state == ADDR) && bus.valid_in && w_alast
                       && !r_wr_en && (READ_LAT == 0))
                   || ((r_state == RWAIT) && (r_wcnt == LAT_M1))
                   || ((r_state == RDATA) && w_dlast && r_burst && bus.burst);

    always_comb begin
        w_load_idx = r_idx;
        if (r_state == ADDR)       w_load_idx = w_anxt[MemN-1:0];
        else if (r_state == RDATA) w_load_idx = r_idx + IDX_ONE;
    end
    assign w_load_word = r_mem[w_load_idx];

    serial_shift_unit #(.W(ADN)) u_addr (
        .clk(clk), .reset(reset), .clr(w_aclr), .load(1'b0),
        .load_val('0), .shift(w_ashift), .sin(bus.addr),
        .q(w_aq), .q_nxt(w_anxt), .first(w_afirst), .last(w_alast)
    );

    serial_shift_unit #(.W(N)) u_data (
        .clk(clk), .reset(reset), .clr(w_dclr), .load(w_dload),
        .load_val(w_load_word), .shift(w_dshift), .sin(bus.data_in),
        .q(w_dq), .q_nxt(w_dnxt), .first(w_dfirst), .last(w_dlast)
    );

    assign w_unused = ^{w_aq, w_anxt, w_afirst, w_dq[0]};

    // Peripheral read samples before the same-edge commit lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**MemN; i++) r_mem[i] <= '0;
            r_prdata <= '0;
        end else begin
            r_prdata <= r_mem[p_addr];
            if (w_commit) r_mem[r_idx] <= w_dnxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_dout      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_abort     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_burst     <= 1'b0;
            r_cont      <= 1'b0;
            r_idx       <= '0;
            r_wcnt      <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_abort     <= 1'b0;
            unique case (r_state)
                IDLE: if (bus.valid_in) begin
                    r_wr_en <= bus.wr_en;
                    r_burst <= bus.burst;
                    r_cont  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= ADDR;
                end
                ADDR: if (!bus.valid_in) begin
                    r_abort <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end else if (w_alast) begin
                    r_idx <= w_anxt[MemN-1:0];
                    if (r_wr_en) begin
                        r_state <= WDATA;
                    end else if (READ_LAT == 0) begin
                        r_valid <= 1'b1;
                        r_dout  <= w_load_word[0];
                        r_state <= RDATA;
                    end else begin
                        r_wcnt  <= '0;
                        r_state <= RWAIT;
                    end
                end
                WDATA: if (!bus.valid_in) begin
                    // A gap on a word boundary after a commit ends a burst cleanly.
                    if (w_dfirst && r_cont) begin
                        r_state <= DONE;
                    end else begin
                        r_abort <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end else if (w_dlast) begin
                    r_wr_strobe <= 1'b1;
                    r_wr_addr   <= r_idx;
                    r_wr_data   <= w_dnxt;
                    if (r_burst) begin
                        r_idx  <= r_idx + IDX_ONE;
                        r_cont <= 1'b1;
                    end else begin
                        r_state <= DONE;
                    end
                end
                RWAIT: if (r_wcnt == LAT_M1) begin
                    r_valid <= 1'b1;
                    r_dout  <= w_load_word[0];
                    r_state <= RDATA;
                end else begin
                    r_wcnt <= r_wcnt + 3'd1;
                end
                RDATA: if (!w_dlast) begin
                    r_dout <= w_dq[1];
                end else if (r_burst && bus.burst) begin
                    r_idx  <= r_idx + IDX_ONE;
                    r_dout <= w_load_word[0];
                end else begin
                    r_valid <= 1'b0;
                    r_dout  <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_dout;
    assign wr_strobe     = r_wr_strobe;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign p_rdata       = r_prdata;
    assign abort         = r_abort;
    assign state_out     = r_state;

endmodule

// File: tb/tb_serial_reg_slave.sv
// Bench for serial_reg_slave: directed bus transactions, scoreboard queue
// filled by stimulus and drained by an output monitor.
module tb_serial_reg_slave;
    import serial_bus_pkg::*;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_AB = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] idx;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_strobe, abort;
    logic [1:0] wr_addr, p_addr;
    logic [7:0] wr_data, p_rdata;
    logic [2:0] state_out;

    int   n_tot = 0;
    int   n_bad = 0;
    exp_t sb[$];

    serial_reg_slave_if bus();

    serial_reg_slave dut (
        .clk(clk), .reset(reset), .bus(bus),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .p_addr(p_addr), .p_rdata(p_rdata),
        .abort(abort), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [1:0] ix, input logic [7:0] v);
        exp_t e;
        e.kind = k;
        e.idx  = ix;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [1:0] k, input logic [1:0] ix, input logic [7:0] v);
        exp_t e;
        if (sb.size() == 0) begin
            n_tot++;
            n_bad++;
            $display("FAIL sb_unexpected: got kind %0d want none", k);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", int'(k), int'(e.kind));
            if (k == K_WR) chk("sb_wr_addr", int'(ix), int'(e.idx));
            if (k != K_AB) chk("sb_val", int'(v), int'(e.val));
        end
    endtask

    task automatic quiet();
        bus.valid_in = 1'b0;
        bus.wr_en    = 1'b0;
        bus.burst    = 1'b0;
        bus.addr     = 1'b0;
        bus.data_in  = 1'b0;
    endtask

    task automatic send_addr(input logic [11:0] a, input logic we,
                             input logic bu, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.valid_in = 1'b1;
            bus.addr     = a[i];
            bus.wr_en    = we;
            bus.burst    = bu;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.valid_in = 1'b1;
            bus.data_in  = w[i];
            @(negedge clk);
        end
    endtask

    // Output monitor: strobes, aborts and serial read words
    initial begin : mon
        int         nb;
        logic [7:0] sh;
        nb = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (wr_strobe || abort)
                chk("strobe_abort_excl", int'(wr_strobe & abort), 0);
            if (wr_strobe) pop_chk(K_WR, wr_addr, wr_data);
            if (abort) pop_chk(K_AB, 2'd0, 8'd0);
            if (bus.valid_out) begin
                sh[nb] = bus.data_out;
                nb++;
                if (nb == 8) begin
                    pop_chk(K_RD, 2'd0, sh);
                    nb = 0;
                end
            end else begin
                nb = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        int         n;
        logic [7:0] bank [4];
        reset  = 1'b1;
        p_addr = '0;
        quiet();
        repeat (2) @(negedge clk);

        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_dout", int'(bus.data_out), 0);
        chk("rst_strobe", int'(wr_strobe), 0);
        chk("rst_abort", int'(abort), 0);
        chk("rst_state", int'(state_out), 0);
        chk("rst_prdata", int'(p_rdata), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write of A5 to index 2
        chk("wr_ready_pre", int'(bus.ready), 1);
        push(K_WR, 2'd2, 8'hA5);
        send_addr(12'h002, 1'b1, 1'b0, 12);
        send_word(8'hA5, 8);
        quiet();
        chk("wr_done_state", int'(state_out), 5);
        chk("wr_done_ready", int'(bus.ready), 0);
        @(negedge clk);
        chk("wr_ready_back", int'(bus.ready), 1);
        p_addr = 2'd2;
        @(negedge clk);
        chk("wr_prdata", int'(p_rdata), 8'hA5);

        // Single read of index 2, READ_LAT=1
        push(K_RD, 2'd0, 8'hA5);
        send_addr(12'h002, 1'b0, 1'b0, 12);
        quiet();
        chk("rd_wait_state", int'(state_out), 3);
        chk("rd_wait_valid", int'(bus.valid_out), 0);
        @(negedge clk);
        chk("rd_first_valid", int'(bus.valid_out), 1);
        chk("rd_first_bit", int'(bus.data_out), 1);
        n = 0;
        while (bus.valid_out && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rd_len", n, 8);
        chk("rd_done_state", int'(state_out), 5);
        @(negedge clk);
        chk("rd_ready_back", int'(bus.ready), 1);

        // Burst write 11,22,33 from index 3 with upper address bits set
        push(K_WR, 2'd3, 8'h11);
        push(K_WR, 2'd0, 8'h22);
        push(K_WR, 2'd1, 8'h33);
        send_addr(12'h5A7, 1'b1, 1'b1, 12);
        send_word(8'h11, 8);
        send_word(8'h22, 8);
        send_word(8'h33, 8);
        quiet();
        @(negedge clk);
        chk("bw_done_state", int'(state_out), 5);
        @(negedge clk);
        chk("bw_ready_back", int'(bus.ready), 1);
        bank[0] = 8'h22;
        bank[1] = 8'h33;
        bank[2] = 8'hA5;
        bank[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            p_addr = 2'(i);
            @(negedge clk);
            chk("bw_bank", int'(p_rdata), int'(bank[i]));
        end

        // Burst read from index 2, burst held through the first boundary
        push(K_RD, 2'd0, 8'hA5);
        push(K_RD, 2'd0, 8'h11);
        send_addr(12'h002, 1'b0, 1'b1, 12);
        quiet();
        bus.burst = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus.valid_out && n < 40) begin
            n++;
            if (n == 9) bus.burst = 1'b0;
            @(negedge clk);
        end
        chk("br_len", n, 16);
        @(negedge clk);
        chk("br_ready_back", int'(bus.ready), 1);

        // Abort after 5 address bits
        push(K_AB, 2'd0, 8'd0);
        send_addr(12'h001, 1'b1, 1'b0, 5);
        quiet();
        @(negedge clk);
        chk("ab_addr_ready", int'(bus.ready), 1);
        chk("ab_addr_state", int'(state_out), 0);
        p_addr = 2'd1;
        @(negedge clk);
        chk("ab_addr_bank", int'(p_rdata), 8'h33);

        // Abort after 3 data bits
        push(K_AB, 2'd0, 8'd0);
        send_addr(12'h001, 1'b1, 1'b0, 12);
        send_word(8'hFF, 3);
        quiet();
        @(negedge clk);
        chk("ab_data_ready", int'(bus.ready), 1);
        @(negedge clk);
        chk("ab_data_bank", int'(p_rdata), 8'h33);

        // Reset in the middle of a read
        send_addr(12'h000, 1'b0, 1'b0, 12);
        quiet();
        @(negedge clk);
        chk("mr_pre_valid", int'(bus.valid_out), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_valid", int'(bus.valid_out), 0);
        chk("mr_ready", int'(bus.ready), 1);
        chk("mr_state", int'(state_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_addr = 2'(i);
            @(negedge clk);
            chk("mr_bank", int'(p_rdata), 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
